// File: rtl/result_writeback.sv
`timescale 1ns/1ps
// result_writeback
// Writes finished SIZE x SIZE result tiles to matrix C, one DMA write burst
// per tile row. Columns past n are masked with zero strobes and zero data.
// Rows past m are consumed from the result stream but never written.
module result_writeback #(
   parameter int unsigned SIZE       = 16,
   parameter int unsigned ELEM_BYTES = 4,
   parameter int unsigned BEATS      = SIZE * ELEM_BYTES / 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic [31:0]  addr_base_c,
   input  logic [31:0]  m,
   input  logic [31:0]  n,
   output logic         busy,
   output logic         done,
   input  logic         res_valid,
   output logic         res_ready,
   input  logic [255:0] res_data,
   output logic         dma_wr_start,
   output logic [31:0]  dma_wr_addr,
   output logic [7:0]   dma_wr_len,
   output logic         dma_wr_valid,
   input  logic         dma_wr_ready,
   output logic [255:0] dma_wr_data,
   output logic [31:0]  dma_wr_strb,
   output logic         dma_wr_last,
   input  logic         dma_wr_done
);

   localparam int unsigned BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned RW        = $clog2(SIZE);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(SIZE - 1);
   localparam logic [32:0]   SIZE_33   = 33'(SIZE);
   // Byte distance between horizontally adjacent tiles
   localparam logic [31:0]   TILE_STEP = 32'(SIZE * ELEM_BYTES);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      DATA = 3'd2,
      RESP = 3'd3,
      SKIP = 3'd4,
      FIN  = 3'd5
   } state_t;

   // True when element e of the given beat falls inside the n columns of C
   function automatic logic col_in_range(input logic [31:0]   n_cnt,
                                         input logic [BW-1:0] beat,
                                         input int unsigned   e,
                                         input logic [31:0]   n_lim);
      logic [32:0] col;
      col = {1'b0, n_cnt} + (33'(beat) << 3) + 33'(e);
      return col < {1'b0, n_lim};
   endfunction

   state_t        state_r, state_nx_s;
   logic [31:0]   m_r, n_r, pitch_r, strip_pitch_r;
   logic [31:0]   m_cnt_r, n_cnt_r;
   logic [RW-1:0] row_r;
   logic [BW-1:0] beat_r;
   logic [31:0]   row_addr_r, tile_addr_r, strip_addr_r;
   logic          busy_r, done_r, wr_start_r;
   logic [31:0]   wr_addr_r;
   logic [7:0]    wr_len_r;

   logic          row_valid_s, beat_last_s, row_last_s, n_wrap_s, m_last_s;
   logic          xfer_s, skip_s, advance_s, empty_job_s;
   logic [31:0]   strb_s;
   logic [255:0]  mask_s;

   // Decode position within the job: row validity, last beat/row/tile
   always_comb begin
      row_valid_s = ({1'b0, m_cnt_r} + 33'(row_r)) < {1'b0, m_r};
      beat_last_s = (beat_r == BEAT_LAST);
      row_last_s  = (row_r == ROW_LAST);
      n_wrap_s    = ({1'b0, n_cnt_r} + SIZE_33) >= {1'b0, n_r};
      m_last_s    = ({1'b0, m_cnt_r} + SIZE_33) >= {1'b0, m_r};
      xfer_s      = (state_r == DATA) && res_valid && dma_wr_ready;
      skip_s      = (state_r == SKIP) && res_valid;
      advance_s   = ((state_r == RESP) && dma_wr_done) || (skip_s && beat_last_s);
      empty_job_s = (m == 32'd0) || (n == 32'd0);
   end

   // Next-state selection
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (empty_job_s) begin
                  state_nx_s = FIN;
               end else begin
                  state_nx_s = REQ;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         REQ: begin
            if (row_valid_s) begin
               state_nx_s = DATA;
            end else begin
               state_nx_s = SKIP;
            end
         end
         DATA: begin
            if (xfer_s && beat_last_s) begin
               state_nx_s = RESP;
            end else begin
               state_nx_s = DATA;
            end
         end
         RESP, SKIP: begin
            if (advance_s) begin
               if (row_last_s && n_wrap_s && m_last_s) begin
                  state_nx_s = FIN;
               end else begin
                  state_nx_s = REQ;
               end
            end else begin
               state_nx_s = state_r;
            end
         end
         FIN:     state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Per-element byte strobes and data mask for the current beat
   always_comb begin
      strb_s = 32'd0;
      mask_s = 256'd0;
      for (int unsigned e = 0; e < 8; e++) begin
         if (col_in_range(n_cnt_r, beat_r, e, n_r)) begin
            strb_s[e*4 +: 4]  = 4'hF;
            mask_s[e*32 +: 32] = 32'hFFFF_FFFF;
         end else begin
            strb_s[e*4 +: 4]  = 4'h0;
            mask_s[e*32 +: 32] = 32'h0000_0000;
         end
      end
   end

   // Beat channel: pass-through in DATA, sink in SKIP, quiet otherwise
   always_comb begin
      res_ready    = 1'b0;
      dma_wr_valid = 1'b0;
      dma_wr_data  = 256'd0;
      dma_wr_strb  = 32'd0;
      dma_wr_last  = 1'b0;
      if (state_r == DATA) begin
         res_ready    = dma_wr_ready;
         dma_wr_valid = res_valid;
         dma_wr_data  = res_data & mask_s;
         dma_wr_strb  = strb_s;
         dma_wr_last  = beat_last_s;
      end else if (state_r == SKIP) begin
         res_ready = 1'b1;
      end else begin
         res_ready = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Job registers, tile/row walk and registered control outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_r           <= 32'd0;
         n_r           <= 32'd0;
         pitch_r       <= 32'd0;
         strip_pitch_r <= 32'd0;
         m_cnt_r       <= 32'd0;
         n_cnt_r       <= 32'd0;
         row_r         <= '0;
         beat_r        <= '0;
         row_addr_r    <= 32'd0;
         tile_addr_r   <= 32'd0;
         strip_addr_r  <= 32'd0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         wr_start_r    <= 1'b0;
         wr_addr_r     <= 32'd0;
         wr_len_r      <= 8'd0;
      end else begin
         done_r     <= 1'b0;
         wr_start_r <= 1'b0;

         if ((state_r == IDLE) && start) begin
            m_r           <= m;
            n_r           <= n;
            pitch_r       <= n * 32'(ELEM_BYTES);
            strip_pitch_r <= n * TILE_STEP;
            m_cnt_r       <= 32'd0;
            n_cnt_r       <= 32'd0;
            row_r         <= '0;
            beat_r        <= '0;
            row_addr_r    <= addr_base_c;
            tile_addr_r   <= addr_base_c;
            strip_addr_r  <= addr_base_c;
            busy_r        <= 1'b1;
            wr_len_r      <= 8'(BEATS);
         end

         // Burst request is issued only for rows inside the matrix
         if ((state_r == REQ) && row_valid_s) begin
            wr_start_r <= 1'b1;
            wr_addr_r  <= row_addr_r;
         end

         if (xfer_s || skip_s) begin
            if (beat_last_s) begin
               beat_r <= '0;
            end else begin
               beat_r <= beat_r + BW'(1);
            end
         end

         // Row advance; at a tile boundary jump to the next tile origin
         if (advance_s) begin
            if (row_last_s) begin
               row_r <= '0;
               if (n_wrap_s) begin
                  n_cnt_r      <= 32'd0;
                  m_cnt_r      <= m_cnt_r + 32'(SIZE);
                  strip_addr_r <= strip_addr_r + strip_pitch_r;
                  tile_addr_r  <= strip_addr_r + strip_pitch_r;
                  row_addr_r   <= strip_addr_r + strip_pitch_r;
               end else begin
                  n_cnt_r     <= n_cnt_r + 32'(SIZE);
                  tile_addr_r <= tile_addr_r + TILE_STEP;
                  row_addr_r  <= tile_addr_r + TILE_STEP;
               end
            end else begin
               row_r      <= row_r + RW'(1);
               row_addr_r <= row_addr_r + pitch_r;
            end
         end

         if (state_r == FIN) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end
      end
   end

   assign busy         = busy_r;
   assign done         = done_r;
   assign dma_wr_start = wr_start_r;
   assign dma_wr_addr  = wr_addr_r;
   assign dma_wr_len   = wr_len_r;

endmodule

// File: tb/tb_result_writeback.sv
`timescale 1ns/1ps
// Scoreboard bench for result_writeback: a result-stream source, a DMA
// write-port model and a monitor that checks every burst and beat.
module tb_result_writeback;

   localparam int SIZE  = 16;
   localparam int BEATS = 2;

   typedef struct {
      logic [255:0] d;
      logic [31:0]  s;
      logic         l;
   } beat_t;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         start = 1'b0;
   logic [31:0]  addr_base_c = 32'd0;
   logic [31:0]  m = 32'd0;
   logic [31:0]  n = 32'd0;
   logic         busy, done;
   logic         res_valid = 1'b0;
   logic         res_ready;
   logic [255:0] res_data = 256'd0;
   logic         dma_wr_start;
   logic [31:0]  dma_wr_addr;
   logic [7:0]   dma_wr_len;
   logic         dma_wr_valid;
   logic         dma_wr_ready = 1'b1;
   logic [255:0] dma_wr_data;
   logic [31:0]  dma_wr_strb;
   logic         dma_wr_last;
   logic         dma_wr_done = 1'b0;

   result_writeback dut (
      .clk(clk), .rstn(rstn), .start(start), .addr_base_c(addr_base_c),
      .m(m), .n(n), .busy(busy), .done(done),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .dma_wr_start(dma_wr_start), .dma_wr_addr(dma_wr_addr), .dma_wr_len(dma_wr_len),
      .dma_wr_valid(dma_wr_valid), .dma_wr_ready(dma_wr_ready),
      .dma_wr_data(dma_wr_data), .dma_wr_strb(dma_wr_strb), .dma_wr_last(dma_wr_last),
      .dma_wr_done(dma_wr_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int n_bursts = 0;
   int n_done = 0;
   int n_skip = 0;
   int resp_cnt = 0;
   bit rnd_mode = 1'b0;
   bit src_fire = 1'b0;
   bit last_fire = 1'b0;
   bit prev_stall = 1'b0;
   logic [255:0] prev_d;
   logic [31:0]  prev_s;
   logic         prev_l;
   beat_t        mon_bt;

   logic [255:0] src_q[$];
   logic [31:0]  exp_addr_q[$];
   beat_t        exp_beat_q[$];
   logic [31:0]  log_addr[$];
   logic [31:0]  log_strb[$];
   logic [255:0] log_data[$];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: expected bursts/beats and source beats for a whole job
   task automatic build_exp(input logic [31:0] base, input logic [31:0] mm, input logic [31:0] nn);
      int unsigned  tiles_m, tiles_n, k, col;
      logic [255:0] d, md;
      logic [31:0]  s;
      bit           row_ok;
      beat_t        bt;
      tiles_m = (mm + 32'd15) / 32'd16;
      tiles_n = (nn + 32'd15) / 32'd16;
      if (mm == 32'd0 || nn == 32'd0) begin
         tiles_m = 0;
      end
      k = 0;
      for (int unsigned ti = 0; ti < tiles_m; ti++) begin
         for (int unsigned tj = 0; tj < tiles_n; tj++) begin
            for (int unsigned r = 0; r < SIZE; r++) begin
               row_ok = (ti * SIZE + r) < mm;
               if (row_ok) begin
                  exp_addr_q.push_back(base + 32'(((ti * SIZE + r) * nn + tj * SIZE) * 4));
               end
               for (int unsigned b = 0; b < BEATS; b++) begin
                  for (int unsigned e = 0; e < 8; e++) begin
                     d[e*32 +: 32] = 32'hC000_0000 | 32'(k * 8 + e);
                     col = tj * SIZE + b * 8 + e;
                     if (col < nn) begin
                        md[e*32 +: 32] = d[e*32 +: 32];
                        s[e*4 +: 4]    = 4'hF;
                     end else begin
                        md[e*32 +: 32] = 32'd0;
                        s[e*4 +: 4]    = 4'h0;
                     end
                  end
                  src_q.push_back(d);
                  if (row_ok) begin
                     bt.d = md;
                     bt.s = s;
                     bt.l = (b == BEATS - 1);
                     exp_beat_q.push_back(bt);
                  end
                  k++;
               end
            end
         end
      end
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [31:0] mm, input logic [31:0] nn);
      @(posedge clk);
      #1;
      addr_base_c = base;
      m = mm;
      n = nn;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_job(input logic [31:0] base, input logic [31:0] mm, input logic [31:0] nn,
                          input bit rnd, input bit restart, input int exp_bursts, input int exp_skip);
      int cyc;
      n_bursts = 0;
      n_done = 0;
      n_skip = 0;
      log_addr.delete();
      log_strb.delete();
      log_data.delete();
      rnd_mode = rnd;
      build_exp(base, mm, nn);
      pulse_start(base, mm, nn);
      @(negedge clk);
      chk("latency_early", {dma_wr_start, done}, 2'b00);
      @(negedge clk);
      if (mm == 32'd0 || nn == 32'd0) begin
         chk("done_latency", done, 1'b1);
      end else begin
         chk("start_latency", dma_wr_start, 1'b1);
      end
      if (restart) begin
         pulse_start(32'h0000_0040, 32'd1, 32'd1);
      end
      cyc = 0;
      while (n_done == 0 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_timeout", n_done != 0, 1'b1);
      repeat (4) @(negedge clk);
      chk("done_count", n_done, 1);
      chk("burst_count", n_bursts, exp_bursts);
      chk("skip_beats", n_skip, exp_skip);
      chk("addr_q_left", exp_addr_q.size(), 0);
      chk("beat_q_left", exp_beat_q.size(), 0);
      chk("busy_after", busy, 1'b0);
   endtask

   // Result source: holds a beat until accepted, optional idle gaps
   always begin : src_proc
      @(posedge clk);
      #1;
      if (!rstn) begin
         src_q.delete();
         res_valid = 1'b0;
         res_data  = 256'd0;
      end else begin
         if (src_fire && src_q.size() > 0) begin
            void'(src_q.pop_front());
         end
         if (src_q.size() > 0 &&
             ((res_valid && !src_fire) || !rnd_mode || $urandom_range(0, 2) != 0)) begin
            res_valid = 1'b1;
            res_data  = src_q[0];
         end else begin
            res_valid = 1'b0;
            res_data  = 256'd0;
         end
      end
   end

   // DMA model: random ready, one done pulse a few cycles after each last beat
   always begin : dma_proc
      @(posedge clk);
      #1;
      dma_wr_done = 1'b0;
      if (!rstn) begin
         resp_cnt = 0;
      end else begin
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               dma_wr_done = 1'b1;
            end
         end
         if (last_fire) begin
            resp_cnt = rnd_mode ? int'($urandom_range(1, 3)) : 1;
         end
      end
      dma_wr_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // Monitor: sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      src_fire  = res_valid && res_ready;
      last_fire = dma_wr_valid && dma_wr_ready && dma_wr_last;
      if (rstn) begin
         if (prev_stall) begin
            chk("stall_valid", dma_wr_valid, 1'b1);
            chk("stall_data", dma_wr_data, prev_d);
            chk("stall_strb", dma_wr_strb, prev_s);
            chk("stall_last", dma_wr_last, prev_l);
         end
         if (dma_wr_start) begin
            n_bursts++;
            log_addr.push_back(dma_wr_addr);
            chk("burst_expected", exp_addr_q.size() != 0, 1'b1);
            if (exp_addr_q.size() != 0) begin
               chk("burst_addr", dma_wr_addr, exp_addr_q.pop_front());
            end
            chk("burst_len", dma_wr_len, 8'(BEATS));
         end
         if (dma_wr_valid && dma_wr_ready) begin
            log_strb.push_back(dma_wr_strb);
            log_data.push_back(dma_wr_data);
            chk("beat_expected", exp_beat_q.size() != 0, 1'b1);
            if (exp_beat_q.size() != 0) begin
               mon_bt = exp_beat_q.pop_front();
               chk("beat_data", dma_wr_data, mon_bt.d);
               chk("beat_strb", dma_wr_strb, mon_bt.s);
               chk("beat_last", dma_wr_last, mon_bt.l);
            end
         end
         if (res_valid && res_ready && !dma_wr_valid) begin
            n_skip++;
         end
         if (done) begin
            n_done++;
            chk("busy_at_done", busy, 1'b0);
         end
      end
      prev_stall = rstn && dma_wr_valid && !dma_wr_ready;
      prev_d = dma_wr_data;
      prev_s = dma_wr_strb;
      prev_l = dma_wr_last;
   end

   logic [255:0] tmp_d;
   int           cyc_m;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_wr_start", dma_wr_start, 1'b0);
      chk("rst_wr_valid", dma_wr_valid, 1'b0);
      chk("rst_res_ready", res_ready, 1'b0);
      chk("rst_wr_len", dma_wr_len, 8'd0);

      // Single aligned tile
      run_job(32'h0000_1000, 32'd16, 32'd16, 1'b0, 1'b0, 16, 0);
      chk("a_addr15", log_addr[15], 32'h0000_13C0);
      chk("a_strb0", log_strb[0], 32'hFFFF_FFFF);

      // Right-edge overhang: n=20
      run_job(32'h0000_2000, 32'd16, 32'd20, 1'b0, 1'b0, 32, 0);
      chk("b_pitch", log_addr[1], 32'h0000_2050);
      chk("b_tile1_addr", log_addr[16], 32'h0000_2040);
      chk("b_tile1_strb0", log_strb[32], 32'h0000_FFFF);
      chk("b_tile1_strb1", log_strb[33], 32'h0000_0000);
      tmp_d = log_data[32];
      chk("b_tile1_hi_zero", tmp_d[255:128], 128'd0);

      // Bottom-edge overhang: m=5
      run_job(32'h0000_3000, 32'd5, 32'd16, 1'b0, 1'b0, 5, 22);

      // Empty matrices
      run_job(32'h0000_4000, 32'd0, 32'd16, 1'b0, 1'b0, 0, 0);
      run_job(32'h0000_4000, 32'd16, 32'd0, 1'b0, 1'b0, 0, 0);

      // Random stalls/gaps, both edges overhang, address wrap, ignored restart
      run_job(32'hFFFF_FC00, 32'd20, 32'd24, 1'b1, 1'b1, 40, 48);

      // Reset in the middle of a burst
      rnd_mode = 1'b0;
      n_bursts = 0;
      build_exp(32'h0000_1000, 32'd16, 32'd16);
      pulse_start(32'h0000_1000, 32'd16, 32'd16);
      cyc_m = 0;
      while (n_bursts < 3 && cyc_m < 500) begin
         @(negedge clk);
         cyc_m++;
      end
      chk("mid_reached", n_bursts >= 3, 1'b1);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", dma_wr_valid, 1'b0);
      chk("mid_rst_ready", res_ready, 1'b0);
      chk("mid_rst_strb", dma_wr_strb, 32'd0);
      chk("mid_rst_addr", dma_wr_addr, 32'd0);
      exp_addr_q.delete();
      exp_beat_q.delete();
      repeat (2) @(posedge clk);
      #3;
      rstn = 1'b1;
      run_job(32'h0000_1000, 32'd16, 32'd16, 1'b0, 1'b0, 16, 0);
      chk("r_addr15", log_addr[15], 32'h0000_13C0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Write-side counterpart of the accelerator's DMA operand loader.
- Accepts finished SIZE x SIZE tiles of 32-bit results from the output buffer as a 256-bit beat stream.
- Writes each tile row to matrix C in memory with one DMA write burst per row.
- Masks columns past n with byte strobes and drops rows past m, so tiles that overhang the matrix edge never corrupt memory.

Parameters:
- SIZE, 16, tile edge in elements; must be a multiple of 8.
- ELEM_BYTES, 4, bytes per result element (fixed 32-bit).
- BEATS, SIZE*ELEM_BYTES/32, 256-bit beats per tile row (derived, 2 at default).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin writing the full C matrix
- addr_base_c  in  32  byte address of C[0][0], row-major, row pitch n*4
- m  in  32  rows of C
- n  in  32  columns of C
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last burst completes
- res_valid  in  1  result beat valid
- res_ready  out  1  result beat accepted
- res_data  in  256  8 elements, element 0 in bits [31:0]
- dma_wr_start  out  1  one-cycle burst request
- dma_wr_addr  out  32  burst byte address, stable from start until dma_wr_done
- dma_wr_len  out  8  beats in burst, always BEATS
- dma_wr_valid  out  1  write beat valid
- dma_wr_ready  in  1  DMA accepts beat
- dma_wr_data  out  256  beat data, masked
- dma_wr_strb  out  32  byte enables
- dma_wr_last  out  1  final beat of burst
- dma_wr_done  in  1  burst write response, one-cycle pulse

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters 0.
- Tile order: n_cnt inner, m_cnt outer, both stepping by SIZE, matching the load order. Within a tile, row 0..SIZE-1; within a row, beat 0..BEATS-1.
- States: IDLE, REQ, DATA, RESP, SKIP, FIN.
- IDLE:
  - start -> register base, m, n; busy=1.
  - If m==0 or n==0 -> FIN.
  - Else: row_addr=addr_base_c, go to REQ.
  - start outside IDLE is ignored.
- Row validity: row is valid iff m_cnt+row < m.
- REQ:
  - Valid row: dma_wr_start=1 for exactly one cycle with dma_wr_addr=row_addr, then -> DATA.
  - Invalid row: -> SKIP, no DMA request.
- DATA: pass-through with combinational handshake.
  - dma_wr_valid=res_valid; res_ready=dma_wr_ready; transfer when both high.
  - dma_wr_last=1 on beat BEATS-1; after the last transfer -> RESP.
- RESP: wait for dma_wr_done, then advance the row.
- SKIP: res_ready=1, dma_wr_valid=0; consume BEATS beats, then advance the row.
- Strobe/mask: element e of beat b maps to global column n_cnt+b*8+e.
  - If that column >= n: its 4 strb bits = 0 and its data bits = 0.
  - Otherwise strb bits = 1 and data is passed through.
  - A beat may therefore carry all-zero strb; burst length stays BEATS.
- Advance row:
  - row_addr += n*4 (32-bit, wraps mod 2^32).
  - If row==SIZE-1, move to the next tile:
    - If n_cnt+SIZE >= n: n_cnt=0, m_cnt+=SIZE.
    - Else: n_cnt+=SIZE.
    - Tile start address = addr_base_c + (m_cnt*n + n_cnt)*4, computed one cycle before REQ. The extra cycle is allowed.
  - If the finished tile was the last one (m_cnt+SIZE >= m and n_cnt+SIZE >= n) -> FIN; else -> REQ.
- FIN: done=1 for one cycle, busy=0, -> IDLE.
- Latency:
  - start -> first dma_wr_start: 2 cycles.
  - dma_wr_done -> next dma_wr_start: at most 2 cycles.
- Back-pressure: dma_wr_data/strb/last are held stable while dma_wr_valid=1 and dma_wr_ready=0.
- dma_wr_done arriving outside RESP is ignored.
- Reset mid-burst abandons the burst; the DMA is reset by the same rstn.

Test Plan:
- m=16, n=16, base 0x1000, always-ready DMA:
  - exactly 16 bursts at 0x1000 + 64*r;
  - all strb 0xFFFFFFFF;
  - one done pulse; busy low afterwards.
- m=16, n=20:
  - 2 tiles, 32 bursts, row pitch 80.
  - Tile 1 row 0 at base+64: beat 0 strb 0x0000FFFF with upper 128 data bits zero; beat 1 strb 0.
- m=5, n=16:
  - 5 bursts only; 22 beats consumed with no DMA activity (res_ready high in SKIP);
  - done after row 15.
- m=0 or n=0: no dma_wr_start; done pulses 2 cycles after start.
- DMA ready toggled randomly, res_valid gaps:
  - no beat lost or duplicated;
  - data stable under stall;
  - dma_wr_last only on beat 1.
- rstn asserted mid-DATA: outputs 0 immediately; a fresh start afterwards reproduces the m=16, n=16 result.
